digest_hex_serializer: RTL
==========================

# digest_hex_serializer

Downstream consumer of the light-hash core. Captures each 64-bit digest when the core flags it ready and streams it out as 16 ASCII hex characters, most-significant nibble first, over a valid/ready byte interface. Digests flagged as invalid are discarded and counted, never serialized. Feeds the byte-wide output/UART path.

## Interface

Parameters:
- DIGEST_W, 64, digest width in bits; must be a multiple of 4; NCHARS = DIGEST_W/4.
- UPPERCASE, 0, 0: hex letters 'a'–'f' (8'h61–8'h66); 1: 'A'–'F' (8'h41–8'h46).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- digest_char  in  DIGEST_W  digest from the hash core; sampled only when digest_ready=1.
- digest_ready  in  1  single-cycle strobe; digest_char is valid this cycle.
- digest_err  in  1  the hash core's invalid-plaintext flag, qualified by digest_ready.
- hex_char  out  8  ASCII hex character.
- hex_valid  out  1  hex_char holds a character.
- hex_ready  in  1  consumer accepts; a transfer occurs on an edge where hex_valid && hex_ready.
- hex_last  out  1  current character is the final one (index NCHARS-1).
- busy  out  1  a digest is held and not yet fully transferred.
- dropped  out  1  one-cycle pulse: a digest_ready arrived while it could not be accepted.
- err_count  out  8  saturating count of digests discarded due to digest_err.

## Operation

- Registers:
  - shift register sr[DIGEST_W-1:0]
  - char index idx, width ceil(log2(NCHARS))
  - FSM state in {IDLE, SEND}.
- Accept condition:
  - state==IDLE, or
  - state==SEND with hex_valid && hex_ready && idx==NCHARS-1 (the last transfer).
- digest_ready && digest_err:
  - If the accept condition holds, the digest is discarded and err_count increments, saturating at 8'hFF.
  - Otherwise, it is a drop.
  - The FSM does not leave IDLE because of an error digest. If the error digest arrives on a last-transfer cycle, the FSM goes to IDLE.
- digest_ready && !digest_err:
  - If the accept condition holds: sr <= digest_char, idx <= 0, state <= SEND.
  - Otherwise: dropped pulses for one cycle on the following cycle. The held digest, idx and state are unaffected.
- In SEND:
  - hex_valid=1.
  - hex_char = ascii(sr[DIGEST_W-1 -: 4]).
  - hex_last = (idx==NCHARS-1).
- On each transfer that is not the last: sr <= sr << 4, idx <= idx+1.
- On the last transfer: state <= IDLE, unless a new valid digest is accepted on the same edge (state stays SEND, idx <= 0).
- ascii(n): n≤9 → 8'h30+n; n≥10 → (UPPERCASE ? 8'h41 : 8'h61) + n-10.
- Outputs in IDLE: hex_valid=0, hex_last=0, hex_char=8'h00.
- busy = (state==SEND).

## Timing

- Reset (asynchronous, rst_n=0), all outputs: hex_char=8'h00, hex_valid=0, hex_last=0, busy=0, dropped=0, err_count=0; state=IDLE, idx=0, sr=0.
- Reset asserted mid-stream aborts the digest immediately. No partial-resume.
- Latency: a digest accepted at edge N has its first character with hex_valid=1 in the cycle after edge N.
- With hex_ready held at 1, all NCHARS characters transfer on consecutive edges N+1..N+NCHARS.
- Back-to-back: a digest accepted on the last-transfer edge gives zero bubble; its first character is presented in the next cycle.
- Backpressure: while hex_valid && !hex_ready, hex_char, hex_last and hex_valid stay stable. hex_valid never drops before the transfer.
- hex_ready is ignored in IDLE.
- dropped is registered; it is high exactly one cycle after the offending edge.
- err_count updates on the edge after the accepted error strobe.

## Test plan

- Digest 64'h0123456789ABCDEF, digest_err=0, hex_ready=1 → chars 30,31,…,39,61,62,63,64,65,66 on 16 consecutive cycles after accept; hex_last only on 8'h66; busy falls after it.
- Same digest with UPPERCASE=1, and hex_ready toggling 1,0,0,1,… → sequence ends …41..46; hex_char stays stable during stalls; exactly 16 transfers.
- digest_ready pulsed at 3rd character, then again on the 16th-transfer edge:
  - 1st pulse → dropped=1 one cycle later, stream unchanged.
  - 2nd pulse accepted → next cycle hex_char = ascii of the new MS nibble with no gap.
- digest_ready with digest_err=1 in IDLE, 300 times → no hex_valid ever; err_count reaches 8'hFF and holds.
- rst_n driven low for one cycle at the 7th character of 64'hFFFF_FFFF_FFFF_FFFF → all outputs 0 at once; a subsequent digest 64'h0 streams sixteen 8'h30.

Source files
------------

// File: rtl/digest_hex_serializer_if.sv
// Byte-wide ASCII hex stream: valid/ready handshake plus end-of-digest marker.
interface digest_hex_serializer_if;
  logic [7:0] hex_char;
  logic       hex_valid;
  logic       hex_ready;
  logic       hex_last;

  modport master (
    output hex_char,
    output hex_valid,
    output hex_last,
    input  hex_ready
  );

  modport slave (
    input  hex_char,
    input  hex_valid,
    input  hex_last,
    output hex_ready
  );
endinterface

// File: rtl/digest_hex_serializer.sv
// Captures each digest from the hash core and streams it as ASCII hex, MS nibble first.
// Error-flagged digests are discarded and counted; strobes that cannot be taken pulse dropped.
module digest_hex_serializer #(
  parameter int unsigned DIGEST_W  = 64,
  parameter int unsigned UPPERCASE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIGEST_W-1:0]  digest_char,
  input  logic                 digest_ready,
  input  logic                 digest_err,
  digest_hex_serializer_if.master hex,
  output logic                 busy,
  output logic                 dropped,
  output logic [7:0]           err_count
);

  localparam int unsigned NCHARS = DIGEST_W / 4;
  localparam int unsigned IDXW   = (NCHARS > 1) ? $clog2(NCHARS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHARS - 1);
  localparam logic [7:0] ALPHA_BASE = (UPPERCASE != 0) ? 8'h41 : 8'h61;

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [DIGEST_W-1:0] sr_q, sr_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic                dropped_q, dropped_d;
  logic [7:0]          err_q, err_d;

  logic       xfer;
  logic       last_xfer;
  logic       accept;
  logic       take_digest;
  logic       take_err;
  logic [3:0] nib;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      idx_q     <= '0;
      dropped_q <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      idx_q     <= idx_d;
      dropped_q <= dropped_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    xfer        = (state_q == SEND) && hex.hex_ready;
    last_xfer   = xfer && (idx_q == LAST_IDX);
    // The slot frees up on the final transfer edge, so a new digest lands with no bubble.
    accept      = (state_q == IDLE) || last_xfer;
    take_digest = digest_ready && !digest_err && accept;
    take_err    = digest_ready && digest_err && accept;
    dropped_d   = digest_ready && !accept;

    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    if (take_digest) begin
      state_d = SEND;
      sr_d    = digest_char;
      idx_d   = '0;
    end else if (last_xfer) begin
      state_d = IDLE;
      idx_d   = '0;
    end else if (xfer) begin
      sr_d  = sr_q << 4;
      idx_d = idx_q + IDXW'(1);
    end

    err_d = err_q;
    if (take_err && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_comb begin
    nib           = sr_q[DIGEST_W-1 -: 4];
    hex.hex_char  = 8'h00;
    hex.hex_valid = 1'b0;
    hex.hex_last  = 1'b0;
    if (state_q == SEND) begin
      hex.hex_valid = 1'b1;
      hex.hex_last  = (idx_q == LAST_IDX);
      if (nib <= 4'd9) begin
        hex.hex_char = 8'h30 + {4'h0, nib};
      end else begin
        hex.hex_char = ALPHA_BASE + {4'h0, nib} - 8'd10;
      end
    end
  end

  assign busy      = (state_q == SEND);
  assign dropped   = dropped_q;
  assign err_count = err_q;

endmodule
